// File: rtl/multicycle_control_unit.sv
// Registered control unit for the 8-bit processor. It decodes the opcode, runs a valid/ready
// instruction handshake, stalls for the multiplier and sequences data-memory accesses on BUSYWAIT.
module multicycle_control_unit #(
    parameter int OPCODE_WIDTH = 8,
    parameter int MUL_CYCLES   = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    INSTR_VALID,
    input  logic [OPCODE_WIDTH-1:0] OPCODE,
    input  logic                    BUSYWAIT,
    output logic                    INSTR_READY,
    output logic                    WRITE_ENABLE,
    output logic [2:0]              ALUOP,
    output logic                    SIGN_CONTROL,
    output logic                    OPERAND_CONTROL,
    output logic [1:0]              BRANCH_CONTROL,
    output logic                    JUMP_CONTROL,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic                    WB_SEL,
    output logic                    ILLEGAL_OP,
    output logic [2:0]              DBG_STATE
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        MUL_WAIT = 3'd2,
        MEM      = 3'd3,
        WB       = 3'd4
    } state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] aluop;
        logic       sign;
        logic       opnd;
        logic [1:0] branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       wb_sel;
        logic       illegal;
    } ctl_t;

    state_t           r_state;
    ctl_t             r_ctl;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_load;

    ctl_t             w_entry_ctl;
    logic             w_upper_zero;
    logic             w_is_mul;
    logic             w_is_mem;
    logic             w_is_load;
    logic             w_accept;

    generate
        if (OPCODE_WIDTH > 8) begin : g_upper
            assign w_upper_zero = ~|OPCODE[OPCODE_WIDTH-1:8];
        end else begin : g_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    // Handshake: an opcode is taken on a rising CLK edge where INSTR_VALID & INSTR_READY are both 1;
    // while INSTR_READY is 0 the presented OPCODE is not consumed and has no effect.
    assign INSTR_READY = (r_state == IDLE) || (r_state == EXEC) || (r_state == WB);
    assign w_accept    = INSTR_VALID & INSTR_READY;

    // Controls for the first cycle after the handshake, whatever state the opcode leads to.
    always_comb begin
        w_entry_ctl = '0;
        w_is_mul    = 1'b0;
        w_is_mem    = 1'b0;
        w_is_load   = 1'b0;
        if (!w_upper_zero) begin
            w_entry_ctl.illegal = 1'b1;
        end else begin
            case (OPCODE[7:0])
                8'h00: begin w_entry_ctl.we = 1'b1; w_entry_ctl.opnd = 1'b1; end
                8'h01: w_entry_ctl.we = 1'b1;
                8'h02: begin w_entry_ctl.we = 1'b1; w_entry_ctl.aluop = 3'b001; end
                8'h03: begin w_entry_ctl.we = 1'b1; w_entry_ctl.aluop = 3'b001; w_entry_ctl.sign = 1'b1; end
                8'h04: begin w_entry_ctl.we = 1'b1; w_entry_ctl.aluop = 3'b010; end
                8'h05: begin w_entry_ctl.we = 1'b1; w_entry_ctl.aluop = 3'b011; end
                8'h06: w_entry_ctl.jump = 1'b1;
                8'h07: begin w_entry_ctl.aluop = 3'b001; w_entry_ctl.sign = 1'b1; w_entry_ctl.branch = 2'b01; end
                8'h08, 8'h09: begin
                    w_is_mem = 1'b1;
                    w_is_load = 1'b1;
                    w_entry_ctl.mem_read = 1'b1;
                    w_entry_ctl.opnd = OPCODE[0];
                end
                8'h0A, 8'h0B: begin
                    w_is_mem = 1'b1;
                    w_entry_ctl.mem_write = 1'b1;
                    w_entry_ctl.opnd = OPCODE[0];
                end
                8'h0C: begin w_is_mul = 1'b1; w_entry_ctl.aluop = 3'b100; end
                8'h0D: begin w_entry_ctl.we = 1'b1; w_entry_ctl.aluop = 3'b101; end
                8'h0E: begin w_entry_ctl.aluop = 3'b001; w_entry_ctl.sign = 1'b1; w_entry_ctl.branch = 2'b10; end
                default: w_entry_ctl.illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_ctl     <= '0;
            r_cnt     <= '0;
            r_is_load <= 1'b0;
        end else if (w_accept) begin
            r_ctl     <= w_entry_ctl;
            r_is_load <= w_is_load;
            r_cnt     <= CNT_LOAD;
            if (w_is_mul) begin
                r_state <= MUL_WAIT;
            end else if (w_is_mem) begin
                r_state <= MEM;
            end else begin
                r_state <= EXEC;
            end
        end else begin
            case (r_state)
                EXEC, WB: begin
                    r_state <= IDLE;
                    r_ctl   <= '0;
                end
                MUL_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state  <= WB;
                        r_ctl.we <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                MEM: begin
                    // Entering MEM took an edge, so any later edge with BUSYWAIT low completes the access.
                    if (!BUSYWAIT) begin
                        if (r_is_load) begin
                            r_state        <= WB;
                            r_ctl.mem_read <= 1'b0;
                            r_ctl.we       <= 1'b1;
                            r_ctl.wb_sel   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_ctl   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ctl   <= '0;
                end
            endcase
        end
    end

    assign WRITE_ENABLE    = r_ctl.we;
    assign ALUOP           = r_ctl.aluop;
    assign SIGN_CONTROL    = r_ctl.sign;
    assign OPERAND_CONTROL = r_ctl.opnd;
    assign BRANCH_CONTROL  = r_ctl.branch;
    assign JUMP_CONTROL    = r_ctl.jump;
    assign MEM_READ        = r_ctl.mem_read;
    assign MEM_WRITE       = r_ctl.mem_write;
    assign WB_SEL          = r_ctl.wb_sel;
    assign ILLEGAL_OP      = r_ctl.illegal;
    assign DBG_STATE       = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-timeline model predicts every output cycle,
// and directed scenarios pin key cycles against literal values.
module tb_multicycle_control_unit;
    localparam int OW   = 9;
    localparam int MULC = 3;
    localparam int W    = 14;
    localparam int RDY  = 13;
    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;
    // Vector layout: {ready, we, aluop[2:0], sign, opnd, branch[1:0], jump, mem_read, mem_write, wb_sel, illegal}
    localparam logic [W-1:0] IDLE_V = 14'h2000;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          INSTR_VALID = 1'b0;
    logic          BUSYWAIT = 1'b0;
    logic [OW-1:0] OPCODE = '0;
    logic          INSTR_READY, WRITE_ENABLE, SIGN_CONTROL, OPERAND_CONTROL, JUMP_CONTROL;
    logic          MEM_READ, MEM_WRITE, WB_SEL, ILLEGAL_OP;
    logic [2:0]    ALUOP;
    logic [1:0]    BRANCH_CONTROL;
    logic [2:0]    DBG_STATE;
    logic [W-1:0]  dut_vec;

    logic [W-1:0]  exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            acc_cnt = 0;
    int            cur_busy = 0;
    bit            checking = 1'b0;

    multicycle_control_unit #(.OPCODE_WIDTH(OW), .MUL_CYCLES(MULC)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE), .BUSYWAIT(BUSYWAIT),
        .INSTR_READY(INSTR_READY), .WRITE_ENABLE(WRITE_ENABLE), .ALUOP(ALUOP),
        .SIGN_CONTROL(SIGN_CONTROL), .OPERAND_CONTROL(OPERAND_CONTROL),
        .BRANCH_CONTROL(BRANCH_CONTROL), .JUMP_CONTROL(JUMP_CONTROL), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .WB_SEL(WB_SEL), .ILLEGAL_OP(ILLEGAL_OP), .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    assign dut_vec = {INSTR_READY, WRITE_ENABLE, ALUOP, SIGN_CONTROL, OPERAND_CONTROL,
                      BRANCH_CONTROL, JUMP_CONTROL, MEM_READ, MEM_WRITE, WB_SEL, ILLEGAL_OP};

    function automatic logic [W-1:0] mk(input logic rdy, input logic we, input logic [2:0] alu,
                                        input logic sign, input logic opnd, input logic [1:0] br,
                                        input logic jmp, input logic mr, input logic mw,
                                        input logic wb, input logic ill);
        return {rdy, we, alu, sign, opnd, br, jmp, mr, mw, wb, ill};
    endfunction

    function automatic logic [W-1:0] exec_vec(input logic [7:0] lo);
        case (lo)
            8'h00:   return mk(L1, L1, 3'b000, L0, L1, 2'b00, L0, L0, L0, L0, L0);
            8'h01:   return mk(L1, L1, 3'b000, L0, L0, 2'b00, L0, L0, L0, L0, L0);
            8'h02:   return mk(L1, L1, 3'b001, L0, L0, 2'b00, L0, L0, L0, L0, L0);
            8'h03:   return mk(L1, L1, 3'b001, L1, L0, 2'b00, L0, L0, L0, L0, L0);
            8'h04:   return mk(L1, L1, 3'b010, L0, L0, 2'b00, L0, L0, L0, L0, L0);
            8'h05:   return mk(L1, L1, 3'b011, L0, L0, 2'b00, L0, L0, L0, L0, L0);
            8'h06:   return mk(L1, L0, 3'b000, L0, L0, 2'b00, L1, L0, L0, L0, L0);
            8'h07:   return mk(L1, L0, 3'b001, L1, L0, 2'b01, L0, L0, L0, L0, L0);
            8'h0D:   return mk(L1, L1, 3'b101, L0, L0, 2'b00, L0, L0, L0, L0, L0);
            8'h0E:   return mk(L1, L0, 3'b001, L1, L0, 2'b10, L0, L0, L0, L0, L0);
            default: return mk(L1, L0, 3'b000, L0, L0, 2'b00, L0, L0, L0, L0, L1);
        endcase
    endfunction

    // Append the per-cycle outputs an accepted instruction produces, from acceptance to completion.
    task automatic push_timeline(input logic [OW-1:0] op, input int busy);
        logic [7:0] lo;
        logic       load;
        logic       imm;
        lo = op[7:0];
        if (op[OW-1:8] != '0 || lo > 8'h0E) begin
            exp_q.push_back(mk(L1, L0, 3'b000, L0, L0, 2'b00, L0, L0, L0, L0, L1));
        end else if (lo == 8'h0C) begin
            for (int i = 0; i < MULC; i++)
                exp_q.push_back(mk(L0, L0, 3'b100, L0, L0, 2'b00, L0, L0, L0, L0, L0));
            exp_q.push_back(mk(L1, L1, 3'b100, L0, L0, 2'b00, L0, L0, L0, L0, L0));
        end else if (lo >= 8'h08 && lo <= 8'h0B) begin
            load = (lo <= 8'h09);
            imm  = lo[0];
            for (int i = 0; i <= busy; i++)
                exp_q.push_back(mk(L0, L0, 3'b000, L0, imm, 2'b00, L0, load, !load, L0, L0));
            if (load)
                exp_q.push_back(mk(L1, L1, 3'b000, L0, imm, 2'b00, L0, L0, L0, L1, L0));
        end else begin
            exp_q.push_back(exec_vec(lo));
        end
    endtask

    // Model: one queue entry per cycle; an instruction is taken when the finishing cycle was ready.
    always @(posedge CLK or posedge RESET) begin
        logic [W-1:0] cur;
        if (RESET) begin
            exp_q.delete();
        end else begin
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
            if (INSTR_VALID && cur[RDY]) begin
                push_timeline(OPCODE, cur_busy);
                acc_cnt++;
            end
        end
    end

    always @(negedge CLK) begin
        logic [W-1:0] expv;
        if (checking) begin
            expv = (exp_q.size() > 0) ? exp_q[0] : IDLE_V;
            total++;
            if (dut_vec !== expv) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, dut_vec, expv);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    task automatic issue(input logic [OW-1:0] op, input int busy);
        int start;
        bit done;
        cur_busy    = busy;
        INSTR_VALID = 1'b1;
        OPCODE      = op;
        start       = acc_cnt;
        done        = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge CLK);
            #1;
            if (acc_cnt != start) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout op=%h got=no_accept exp=accept", op);
        end
        INSTR_VALID = 1'b0;
        OPCODE      = OW'($urandom_range(0, 511));
        BUSYWAIT    = (busy > 0);
    endtask

    task automatic run_op(input logic [OW-1:0] op, input int busy);
        issue(op, busy);
        if (busy > 0) begin
            repeat (busy) @(posedge CLK);
            #1 BUSYWAIT = 1'b0;
        end
    endtask

    logic [OW-1:0] b2b_ops [4] = '{9'h003, 9'h007, 9'h00E, 9'h006};
    logic [4:0]    b2b_exp [4] = '{5'b11000, 5'b01010, 5'b01100, 5'b00001};
    logic [OW-1:0] mix_ops [10] = '{9'h000, 9'h001, 9'h004, 9'h00D, 9'h008,
                                    9'h00B, 9'h009, 9'h00C, 9'h00E, 9'h005};
    int            mix_busy[10] = '{0, 0, 0, 0, 0, 2, 1, 0, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset asserted between clock edges must clear outputs at once.
        #2 RESET = 1'b1;
        #1;
        chk("reset_outputs", 32'(dut_vec), 32'(IDLE_V));
        chk("reset_state", 32'(DBG_STATE), 32'(3'd0));
        checking = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #3 RESET = 1'b0;

        issue(9'h002, 0);
        @(negedge CLK);
        chk("add_exec", 32'({INSTR_READY, WRITE_ENABLE, ALUOP}), 32'(5'b11001));
        @(negedge CLK);
        chk("add_then_idle", 32'({INSTR_READY, WRITE_ENABLE, ALUOP}), 32'(5'b10000));

        for (int i = 0; i < 4; i++) begin
            issue(b2b_ops[i], 0);
            if (i < 3) begin
                INSTR_VALID = 1'b1;
                OPCODE      = b2b_ops[i+1];
            end
            @(negedge CLK);
            chk("b2b_ctl", 32'({WRITE_ENABLE, SIGN_CONTROL, BRANCH_CONTROL, JUMP_CONTROL}), 32'(b2b_exp[i]));
        end

        issue(9'h00C, 0);
        INSTR_VALID = 1'b1;
        OPCODE      = 9'h005;
        for (int k = 0; k < MULC; k++) begin
            @(negedge CLK);
            chk("mul_stall", 32'({INSTR_READY, WRITE_ENABLE, ALUOP}), 32'(5'b00100));
        end
        @(negedge CLK);
        chk("mul_wb", 32'({INSTR_READY, WRITE_ENABLE, ALUOP}), 32'(5'b11100));
        @(negedge CLK);
        chk("or_after_mul", 32'({INSTR_READY, WRITE_ENABLE, ALUOP}), 32'(5'b11011));
        INSTR_VALID = 1'b0;

        issue(9'h009, 4);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("lwi_mem", 32'({MEM_READ, OPERAND_CONTROL, INSTR_READY, WRITE_ENABLE}), 32'(4'b1100));
            if (k < 4) begin
                BUSYWAIT = 1'b0;
                #1 BUSYWAIT = 1'b1;
            end else begin
                BUSYWAIT = 1'b0;
            end
        end
        @(negedge CLK);
        chk("lwi_wb", 32'({WRITE_ENABLE, WB_SEL, OPERAND_CONTROL, MEM_READ, INSTR_READY}), 32'(5'b11101));

        issue(9'h00A, 0);
        @(negedge CLK);
        chk("swd_mem", 32'({MEM_WRITE, WRITE_ENABLE, INSTR_READY}), 32'(3'b100));
        @(negedge CLK);
        chk("swd_no_wb", 32'({MEM_WRITE, WRITE_ENABLE, INSTR_READY}), 32'(3'b001));

        issue(9'h00A, 5);
        @(negedge CLK);
        chk("swd_abort_pre", 32'({MEM_WRITE, INSTR_READY}), 32'(2'b10));
        #2 RESET = 1'b1;
        #1;
        chk("swd_abort_drop", 32'({MEM_WRITE, INSTR_READY}), 32'(2'b01));
        chk("swd_abort_state", 32'(DBG_STATE), 32'(3'd0));
        BUSYWAIT = 1'b0;
        @(posedge CLK);
        #3 RESET = 1'b0;

        issue(9'h00F, 0);
        @(negedge CLK);
        chk("illegal_0f", 32'(dut_vec), 32'(14'h2001));
        issue(9'h102, 0);
        @(negedge CLK);
        chk("illegal_102", 32'(dut_vec), 32'(14'h2001));
        @(negedge CLK);
        chk("illegal_pulse_end", 32'(ILLEGAL_OP), 32'(1'b0));

        for (int i = 0; i < 10; i++) run_op(mix_ops[i], mix_busy[i]);
        INSTR_VALID = 1'b0;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        chk("final_state", 32'(DBG_STATE), 32'(3'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
